// File: rtl/cache_store.sv
// cache_store: four-entry associative store with 2-bit LRU counters and a write-through
// backing-memory port. Hit detection and victim choice come from an external lookup stage.
module cache_store #(
  parameter int d_width = 8,
  parameter int a_width = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [a_width-1:0]   addr,
  input  logic [d_width-1:0]   wdata,
  output logic [d_width-1:0]   rdata,
  output logic                 ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [a_width-1:0]   mem_addr,
  output logic [d_width-1:0]   mem_wdata,
  input  logic [d_width-1:0]   mem_rdata,
  input  logic                 mem_ack,
  output logic [a_width-1:0]   lk_addr,
  output logic [4*a_width-1:0] w_entry_addrs,
  output logic [7:0]           w_cnt,
  output logic [3:0]           valid,
  input  logic [1:0]           sel,
  input  logic [3:0]           dec,
  input  logic                 hit
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [a_width-1:0] tag_r  [4];
  logic [d_width-1:0] data_r [4];
  logic [7:0]         cnt_r;
  logic [3:0]         valid_r;
  logic               lk_we_r;
  logic [d_width-1:0] lk_wdata_r;
  logic [7:0]         touch_cnt_s;

  // Selected entry becomes most-recent; flagged others age by one, never below zero.
  function automatic logic [7:0] touch(input logic [7:0] cnt, input logic [1:0] idx,
                                       input logic [3:0] dec_mask);
    logic [7:0] res;
    res = cnt;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == idx) begin
        res[2*i +: 2] = 2'd3;
      end else if (dec_mask[i] && (cnt[2*i +: 2] != 2'd0)) begin
        res[2*i +: 2] = cnt[2*i +: 2] - 2'd1;
      end else begin
        res[2*i +: 2] = cnt[2*i +: 2];
      end
    end
    return res;
  endfunction

  assign touch_cnt_s = touch(cnt_r, sel, dec);
  assign w_cnt       = cnt_r;
  assign valid       = valid_r;

  for (genvar g = 0; g < 4; g++) begin : g_tags
    assign w_entry_addrs[g*a_width +: a_width] = tag_r[g];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) state_s = LOOKUP;
        else     state_s = IDLE;
      end
      LOOKUP: begin
        if (lk_we_r)  state_s = MEM_WR;
        else if (hit) state_s = IDLE;
        else          state_s = MEM_RD;
      end
      MEM_RD: begin
        if (mem_ack) state_s = IDLE;
        else         state_s = MEM_RD;
      end
      MEM_WR: begin
        if (mem_ack) state_s = IDLE;
        else         state_s = MEM_WR;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: access latch, entry storage, LRU counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        tag_r[i]  <= '0;
        data_r[i] <= '0;
      end
      cnt_r      <= 8'd0;
      valid_r    <= 4'd0;
      lk_addr    <= '0;
      lk_we_r    <= 1'b0;
      lk_wdata_r <= '0;
      rdata      <= '0;
      ready      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      ready <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            lk_addr    <= addr;
            lk_we_r    <= we;
            lk_wdata_r <= wdata;
          end
        end
        LOOKUP: begin
          if (lk_we_r) begin
            // Write-through: update a hit in place, always forward to memory.
            if (hit) begin
              data_r[sel] <= lk_wdata_r;
              cnt_r       <= touch_cnt_s;
            end
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= lk_addr;
            mem_wdata <= lk_wdata_r;
          end else if (hit) begin
            rdata <= data_r[sel];
            ready <= 1'b1;
            cnt_r <= touch_cnt_s;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= lk_addr;
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            tag_r[sel]   <= lk_addr;
            data_r[sel]  <= mem_rdata;
            valid_r[sel] <= 1'b1;
            cnt_r        <= touch_cnt_s;
            rdata        <= mem_rdata;
            ready        <= 1'b1;
            mem_req      <= 1'b0;
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            ready   <= 1'b1;
          end
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_store.md
CACHE_STORE -- requirements
Module: cache_store

Interface
REQ-001 Parameter d_width, default 8, data bus width.
REQ-002 Parameter a_width, default 8, address width.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 req  in  1  CPU access request; sampled only in IDLE.
REQ-007 we  in  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  in  a_width  CPU address; sampled with req.
REQ-009 wdata  in  d_width  CPU write data; sampled with req.
REQ-010 rdata  out  d_width  read result; valid while ready=1.
REQ-011 ready  out  1  one-cycle completion pulse.
REQ-012 mem_req  out  1  backing-memory request; held until mem_ack.
REQ-013 mem_we  out  1  backing-memory write strobe qualifier.
REQ-014 mem_addr  out  a_width  backing-memory address.
REQ-015 mem_wdata  out  d_width  backing-memory write data.
REQ-016 mem_rdata  in  d_width  backing-memory read data; valid with mem_ack.
REQ-017 mem_ack  in  1  backing-memory completion; one cycle.
REQ-018 lk_addr  out  a_width  latched access address, driven to the hit-lookup stage.
REQ-019 w_entry_addrs  out  4*a_width  entry tags; entry i at bits [(i+1)*a_width-1 : i*a_width].
REQ-020 w_cnt  out  8  2-bit LRU counts; entry i at bits [2i+1:2i].
REQ-021 valid  out  4  entry valid bits.
REQ-022 sel  in  2  entry index from the lookup stage: hit entry, or victim on a miss.
REQ-023 dec  in  4  counters to decrement from the lookup stage.
REQ-024 hit  in  1  lookup result for lk_addr.

Function
REQ-025 Storage is 4 entries, each holding a tag (a_width), data (d_width), cnt (2 bits) and a valid bit.
REQ-026 FSM states are IDLE, LOOKUP, MEM_RD and MEM_WR.
REQ-027 IDLE with req=1: latch addr/we/wdata into lk_addr/lk_we/lk_wdata; next state LOOKUP.
REQ-028 req is ignored in every state other than IDLE.
REQ-029 LOOKUP, read, hit=1: rdata<=data[sel]; ready<=1; touch sel (REQ-034); next state IDLE, so ready is high 2 cycles after req is sampled.
REQ-030 LOOKUP, read, hit=0: mem_req<=1, mem_we<=0, mem_addr<=lk_addr; next state MEM_RD.
REQ-031 MEM_RD with mem_ack=1:
  - entry sel: tag<=lk_addr, data<=mem_rdata, valid<=1, touched
  - rdata<=mem_rdata, ready<=1, mem_req<=0; next state IDLE
  - sel is the victim index presented by the lookup stage for the unchanged lk_addr.
REQ-032 LOOKUP, write (write-through, no write-allocate):
  - if hit=1: data[sel]<=lk_wdata and sel is touched
  - in all cases: mem_req<=1, mem_we<=1, mem_addr<=lk_addr, mem_wdata<=lk_wdata; next state MEM_WR.
REQ-033 MEM_WR with mem_ack=1: mem_req<=0, mem_we<=0, ready<=1; next state IDLE. A write miss does not fill the cache.
REQ-034 Touch, in a single cycle:
  - cnt[sel]<=3
  - for every i != sel with dec[i]=1: cnt[i]<=cnt[i]-1, saturating at 0 (never wraps 0 to 3).
REQ-035 No counter changes except on a touch.
REQ-036 ready is a single-cycle pulse; rdata holds its last value when ready=0.
REQ-037 mem_req, mem_we, mem_addr and mem_wdata are registered and stable while mem_req=1.
REQ-038 mem_ack is ignored outside MEM_RD and MEM_WR.
REQ-039 A mem_ack in the same cycle that mem_req first rises completes normally on the next edge.

Reset
REQ-040 reset_n=0 at a clock edge: state<=IDLE and all of the following go to 0:
  - valid, every cnt, every tag, every data word
  - ready, rdata, mem_req, mem_we, mem_addr, mem_wdata, lk_addr.
REQ-041 Reset mid-operation abandons the access: no ready pulse and no fill occur, even if mem_ack arrives in the reset cycle.
REQ-042 reset_n has priority over every other input.

Verification
REQ-043 Cold read miss: reset, then read 0x12, memory returns 0xA5 after 3 cycles -> valid[0]=1, tag0=0x12, cnt0=3, rdata=0xA5 with a one-cycle ready pulse.
REQ-044 Read hit: repeat the read of 0x12 -> ready high exactly 2 cycles after req, no mem_req, rdata=0xA5, cnt0 stays 3.
REQ-045 Fill all entries then evict:
  - fill 0x10, 0x20, 0x30, 0x40, then read 0x50
  - required: the victim is the entry the lookup stage selects with count 0, its tag becomes 0x50, its cnt becomes 3
  - no other cnt underflows below 0.
REQ-046 Write hit and write miss:
  - write 0x5A to cached 0x20 -> data updated, mem_we=1, mem_addr=0x20 until ack
  - write to uncached 0x77 -> memory write only, no tag changes.
REQ-047 Reset during MEM_RD with mem_ack in the same cycle -> no ready pulse, valid=0000, mem_req=0 on the next cycle.
REQ-048 req held high during MEM_RD -> ignored; exactly one access completes per accepted req.
